// File: rtl/spi_master_fd_if.sv
// Bus bundle for the full-duplex SPI master: the master modport is the
// controller side, the slave modport is whatever drives requests and the MISO line.
interface spi_master_fd_if #(
    parameter int DATAWIDTH = 32,
    parameter int LENW      = 6
) ();
    logic                 start;
    logic [DATAWIDTH-1:0] tx_data;
    logic [LENW-1:0]      nbits;
    logic                 cpol;
    logic                 cpha;
    logic                 miso;
    logic                 sclk;
    logic                 mosi;
    logic                 cs_n;
    logic [DATAWIDTH-1:0] rx_data;
    logic                 busy;
    logic                 done;

    modport master (
        input  start, tx_data, nbits, cpol, cpha, miso,
        output sclk, mosi, cs_n, rx_data, busy, done
    );

    modport slave (
        output start, tx_data, nbits, cpol, cpha, miso,
        input  sclk, mosi, cs_n, rx_data, busy, done
    );
endinterface

// File: rtl/spi_master_fd.sv
// Full-duplex SPI master, all four CPOL/CPHA modes, 1..DATAWIDTH bits per transfer.
// Receive path is built only when SPI_MASTER_FD_MISO_EN is defined.
module spi_master_fd #(
    parameter int DATAWIDTH = 32,
    parameter int CLKDIV    = 16,
    parameter int LENW      = 6
) (
    input logic            clk,
    input logic            rst_n,
    spi_master_fd_if.master bus
);
    typedef enum logic [1:0] {IDLE, SETUP, XFER, HOLD} state_e;

    localparam int CW = $clog2(CLKDIV + 1);
    localparam int EW = $clog2(2 * DATAWIDTH);
    localparam logic [CW-1:0] DIV_LAST = CW'(CLKDIV - 1);
    localparam logic [CW-1:0] DIV_HOLD = CW'(CLKDIV);

    state_e               state_q, state_d;
    logic [CW-1:0]        div_q, div_d;
    logic [EW-1:0]        edge_q, edge_d;
    logic [LENW-1:0]      len_q, len_d;
    logic                 cpol_q, cpol_d;
    logic                 cpha_q, cpha_d;
    logic [DATAWIDTH-1:0] tx_sh_q, tx_sh_d;
    logic                 sclk_q, sclk_d;
    logic                 mosi_q, mosi_d;
    logic                 cs_n_q, cs_n_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [DATAWIDTH-1:0] rx_data_q, rx_data_d;
`ifdef SPI_MASTER_FD_MISO_EN
    logic [DATAWIDTH-1:0] rx_sh_q, rx_sh_d;
`endif

    logic [LENW-1:0]      len_in_s;
    logic [DATAWIDTH-1:0] tx_aligned_s;
    logic                 tick_s;
    logic                 last_edge_s;
    logic                 leading_s;

    assign bus.sclk    = sclk_q;
    assign bus.mosi    = mosi_q;
    assign bus.cs_n    = cs_n_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_data = rx_data_q;

    // Next-state and datapath computation for the transfer FSM.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        edge_d    = edge_q;
        len_d     = len_q;
        cpol_d    = cpol_q;
        cpha_d    = cpha_q;
        tx_sh_d   = tx_sh_q;
        sclk_d    = sclk_q;
        mosi_d    = mosi_q;
        cs_n_d    = cs_n_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        rx_data_d = rx_data_q;
`ifdef SPI_MASTER_FD_MISO_EN
        rx_sh_d   = rx_sh_q;
`endif

        if ((bus.nbits == {LENW{1'b0}}) || (bus.nbits > LENW'(DATAWIDTH))) begin
            len_in_s = LENW'(DATAWIDTH);
        end else begin
            len_in_s = bus.nbits;
        end
        // Left-justify so the next outgoing bit is always the shift register MSB.
        tx_aligned_s = bus.tx_data << (DATAWIDTH - int'(len_in_s));
        tick_s       = (div_q == DIV_LAST);
        last_edge_s  = ((LENW+1)'(edge_q) == ({len_q, 1'b0} - {{LENW{1'b0}}, 1'b1}));
        leading_s    = ~edge_q[0];

        case (state_q)
            IDLE: begin
                sclk_d = bus.cpol;
                mosi_d = 1'b0;
                if (bus.start) begin
                    state_d = SETUP;
                    div_d   = {CW{1'b0}};
                    edge_d  = {EW{1'b0}};
                    len_d   = len_in_s;
                    cpol_d  = bus.cpol;
                    cpha_d  = bus.cpha;
                    busy_d  = 1'b1;
                    cs_n_d  = 1'b0;
`ifdef SPI_MASTER_FD_MISO_EN
                    rx_sh_d = {DATAWIDTH{1'b0}};
`endif
                    if (bus.cpha) begin
                        tx_sh_d = tx_aligned_s;
                    end else begin
                        mosi_d  = tx_aligned_s[DATAWIDTH-1];
                        tx_sh_d = {tx_aligned_s[DATAWIDTH-2:0], 1'b0};
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            SETUP: begin
                sclk_d = cpol_q;
                if (tick_s) begin
                    state_d = XFER;
                    div_d   = {CW{1'b0}};
                end else begin
                    div_d = div_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            XFER: begin
                if (tick_s) begin
                    div_d  = {CW{1'b0}};
                    sclk_d = ~sclk_q;
                    edge_d = edge_q + {{(EW-1){1'b0}}, 1'b1};
                    // Shift on the edge opposite to the one the slave samples on.
                    if (leading_s == cpha_q) begin
                        if (!last_edge_s) begin
                            mosi_d  = tx_sh_q[DATAWIDTH-1];
                            tx_sh_d = {tx_sh_q[DATAWIDTH-2:0], 1'b0};
                        end else begin
                            mosi_d = mosi_q;
                        end
                    end else begin
`ifdef SPI_MASTER_FD_MISO_EN
                        rx_sh_d = {rx_sh_q[DATAWIDTH-2:0], bus.miso};
`else
                        mosi_d = mosi_q;
`endif
                    end
                    if (last_edge_s) begin
                        state_d = HOLD;
                        edge_d  = {EW{1'b0}};
                    end else begin
                        state_d = XFER;
                    end
                end else begin
                    div_d = div_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            HOLD: begin
                sclk_d = cpol_q;
                if (div_q == DIV_HOLD) begin
                    state_d = IDLE;
                    div_d   = {CW{1'b0}};
                    busy_d  = 1'b0;
                    cs_n_d  = 1'b1;
                    done_d  = 1'b1;
`ifdef SPI_MASTER_FD_MISO_EN
                    rx_data_d = rx_sh_q;
`endif
                end else begin
                    div_d = div_q + {{(CW-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                div_d   = {CW{1'b0}};
                edge_d  = {EW{1'b0}};
                busy_d  = 1'b0;
                cs_n_d  = 1'b1;
                mosi_d  = 1'b0;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            div_q     <= {CW{1'b0}};
            edge_q    <= {EW{1'b0}};
            len_q     <= {LENW{1'b0}};
            cpol_q    <= 1'b0;
            cpha_q    <= 1'b0;
            tx_sh_q   <= {DATAWIDTH{1'b0}};
            sclk_q    <= 1'b0;
            mosi_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rx_data_q <= {DATAWIDTH{1'b0}};
`ifdef SPI_MASTER_FD_MISO_EN
            rx_sh_q   <= {DATAWIDTH{1'b0}};
`endif
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            edge_q    <= edge_d;
            len_q     <= len_d;
            cpol_q    <= cpol_d;
            cpha_q    <= cpha_d;
            tx_sh_q   <= tx_sh_d;
            sclk_q    <= sclk_d;
            mosi_q    <= mosi_d;
            cs_n_q    <= cs_n_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            rx_data_q <= rx_data_d;
`ifdef SPI_MASTER_FD_MISO_EN
            rx_sh_q   <= rx_sh_d;
`endif
        end
    end
endmodule

// File: tb/tb_spi_master_fd.sv
// Directed bench for spi_master_fd (CLKDIV=4, DATAWIDTH=32): vector table plus
// hand sequences for start-while-busy and mid-transfer reset.
module tb_spi_master_fd;
    typedef struct {
        logic        cpol;
        logic        cpha;
        logic [5:0]  nbits;
        logic [31:0] tx;
        logic [31:0] sl_word;
        int          sl_len;
        logic        loop;
        logic [31:0] exp_rx;
        logic [31:0] exp_mosi;
        int          exp_rises;
        int          exp_lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    spi_master_fd_if #(.DATAWIDTH(32), .LENW(6)) bus ();

    spi_master_fd #(.DATAWIDTH(32), .CLKDIV(4), .LENW(6)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    // Slave model state
    logic        sl_cpol = 1'b0;
    logic        sl_cpha = 1'b0;
    logic        sl_loop = 1'b0;
    logic [31:0] sl_word = 32'h0;
    int          sl_len  = 0;
    int          sl_idx  = -1;
    logic [63:0] mosi_cap = 64'h0;
    int          rises = 0;
    logic        sclk_prev = 1'b0;
    logic        cs_prev = 1'b1;

    always @(posedge clk) begin
        #1;
        if (cs_prev && !bus.cs_n) begin
            sl_idx   = sl_len - 1;
            mosi_cap = 64'h0;
            rises    = 0;
        end else if (!bus.cs_n && (bus.sclk != sclk_prev)) begin
            if (bus.sclk && !sclk_prev) rises++;
            if ((bus.sclk != sl_cpol) == !sl_cpha) begin
                mosi_cap = {mosi_cap[62:0], bus.mosi};
                sl_idx   = sl_idx - 1;
            end
        end
        sclk_prev = bus.sclk;
        cs_prev   = bus.cs_n;
        if (sl_loop) bus.miso = bus.mosi;
        else if (sl_idx >= 0 && sl_idx < 32) bus.miso = sl_word[sl_idx];
        else bus.miso = 1'b0;
    end

    function automatic logic [31:0] rx_exp(input logic [31:0] v);
`ifdef SPI_MASTER_FD_MISO_EN
        return v;
`else
        return 32'h0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic run_vector(input vec_t v);
        int lat;
        @(negedge clk);
        bus.cpol = v.cpol;
        bus.cpha = v.cpha;
        sl_cpol  = v.cpol;
        sl_cpha  = v.cpha;
        sl_loop  = v.loop;
        sl_word  = v.sl_word;
        sl_len   = v.sl_len;
        @(negedge clk);
        chk("idle_sclk_follows_cpol", {63'h0, bus.sclk}, {63'h0, v.cpol});
        bus.start   = 1'b1;
        bus.tx_data = v.tx;
        bus.nbits   = v.nbits;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        bus.tx_data = ~v.tx;
        bus.nbits   = 6'd3;
        bus.cpha    = ~v.cpha;
        chk("busy_on_accept", {63'h0, bus.busy}, 64'h1);
        chk("cs_n_on_accept", {63'h0, bus.cs_n}, 64'h0);
        lat = 0;
        for (int k = 1; k <= v.exp_lat + 20; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk("done_latency", 64'(lat), 64'(v.exp_lat));
        chk("rx_data", {32'h0, bus.rx_data}, {32'h0, rx_exp(v.exp_rx)});
        chk("mosi_stream", mosi_cap, {32'h0, v.exp_mosi});
        chk("sclk_rises", 64'(rises), 64'(v.exp_rises));
        chk("busy_after", {63'h0, bus.busy}, 64'h0);
        chk("cs_n_after", {63'h0, bus.cs_n}, 64'h1);
        chk("sclk_idle_after", {63'h0, bus.sclk}, {63'h0, v.cpol});
        @(posedge clk);
        #1;
        chk("done_one_cycle", {63'h0, bus.done}, 64'h0);
        chk("mosi_idle_zero", {63'h0, bus.mosi}, 64'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[8];
        int   dones;
        int   lat;

        vecs[0] = '{1'b0, 1'b0, 6'd8,  32'h000000A5, 32'h0,        0,  1'b1, 32'h000000A5, 32'h000000A5, 8,  73};
        vecs[1] = '{1'b1, 1'b1, 6'd32, 32'hDEADBEEF, 32'h12345678, 32, 1'b0, 32'h12345678, 32'hDEADBEEF, 32, 265};
        vecs[2] = '{1'b0, 1'b1, 6'd1,  32'h00000001, 32'h00000001, 1,  1'b0, 32'h00000001, 32'h00000001, 1,  17};
        vecs[3] = '{1'b1, 1'b0, 6'd1,  32'h00000001, 32'h00000001, 1,  1'b0, 32'h00000001, 32'h00000001, 1,  17};
        vecs[4] = '{1'b0, 1'b0, 6'd0,  32'h80000001, 32'hCAFEF00D, 32, 1'b0, 32'hCAFEF00D, 32'h80000001, 32, 265};
        vecs[5] = '{1'b0, 1'b1, 6'd40, 32'h0F0F1234, 32'h55AA33CC, 32, 1'b0, 32'h55AA33CC, 32'h0F0F1234, 32, 265};
        vecs[6] = '{1'b1, 1'b0, 6'd5,  32'hFFFFFFF3, 32'h0000000B, 5,  1'b0, 32'h0000000B, 32'h00000013, 5,  49};
        vecs[7] = '{1'b1, 1'b1, 6'd16, 32'h0001C3A5, 32'h0,        0,  1'b1, 32'h0000C3A5, 32'h0000C3A5, 16, 137};

        bus.start   = 1'b0;
        bus.tx_data = 32'h0;
        bus.nbits   = 6'd0;
        bus.cpol    = 1'b0;
        bus.cpha    = 1'b0;
        rst_n       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_sclk", {63'h0, bus.sclk}, 64'h0);
        chk("reset_mosi", {63'h0, bus.mosi}, 64'h0);
        chk("reset_cs_n", {63'h0, bus.cs_n}, 64'h1);
        chk("reset_busy", {63'h0, bus.busy}, 64'h0);
        chk("reset_done", {63'h0, bus.done}, 64'h0);
        chk("reset_rx", {32'h0, bus.rx_data}, 64'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_vector(vecs[i]);
        end

        // Start re-pulsed mid-transfer and cpol toggled: both must be ignored.
        @(negedge clk);
        bus.cpol = 1'b0; bus.cpha = 1'b0;
        sl_cpol = 1'b0; sl_cpha = 1'b0; sl_loop = 1'b1;
        @(negedge clk);
        bus.start = 1'b1; bus.tx_data = 32'h0000003C; bus.nbits = 6'd8;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        dones = 0;
        lat = 0;
        for (int k = 1; k <= 160; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                dones++;
                if (lat == 0) lat = k;
            end
            bus.start = (k == 9);
            if (k == 9) bus.tx_data = 32'h000000FF;
            if (k == 11) bus.cpol = 1'b1;
        end
        chk("busy_start_done_count", 64'(dones), 64'd1);
        chk("busy_start_latency", 64'(lat), 64'd73);
        chk("busy_start_rises", 64'(rises), 64'd8);
        chk("busy_start_mosi", mosi_cap, 64'h3C);
        chk("busy_start_rx", {32'h0, bus.rx_data}, {32'h0, rx_exp(32'h0000003C)});
        chk("cpol_follow_idle", {63'h0, bus.sclk}, 64'h1);

        // Reset at cycle 30 of a 16-bit transfer aborts it.
        @(negedge clk);
        bus.cpol = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.tx_data = 32'h0000BEEF; bus.nbits = 6'd16;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (30) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("abort_cs_n", {63'h0, bus.cs_n}, 64'h1);
        chk("abort_busy", {63'h0, bus.busy}, 64'h0);
        chk("abort_done", {63'h0, bus.done}, 64'h0);
        chk("abort_rx", {32'h0, bus.rx_data}, 64'h0);
        chk("abort_sclk", {63'h0, bus.sclk}, 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int k = 0; k < 120; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) dones++;
        end
        chk("abort_no_done", 64'(dones), 64'd0);
        run_vector(vecs[0]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
